// File: rtl/clock_display_mux.sv
// Snapshots the asynchronous sec/min/hour bus, converts it to BCD and scans six common-anode 7-segment digits (HH.MM.SS).
// Optional macro COLON_BLINK_EN: the separators on digits 2 and 4 light only while the snapshot seconds value is even.
module clock_display_mux #(
  parameter int CLK_HZ  = 50000000,
  parameter int SCAN_HZ = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sec,
  input  logic [5:0] min,
  input  logic [4:0] hour,
  input  logic       disp_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);
  localparam logic [3:0]    DASH = 4'hF;

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [5:0] r;
    logic [3:0] t;
    r = v;
    t = 4'd0;
    if (r >= 6'd40) begin r = r - 6'd40; t = t + 4'd4; end
    if (r >= 6'd20) begin r = r - 6'd20; t = t + 4'd2; end
    if (r >= 6'd10) begin r = r - 6'd10; t = t + 4'd1; end
    return {t, r[3:0]};
  endfunction

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Two-stage sampler; the snapshot only accepts a value seen on two consecutive samples.
  logic [16:0] s1_q, s2_q, snap_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      snap_q <= '0;
    end else begin
      s1_q <= {hour, min, sec};
      s2_q <= s1_q;
      if (s1_q == s2_q) snap_q <= s2_q;
    end
  end

  logic [5:0] fld [3];
  logic [3:0] dig [6];
  assign fld[0] = snap_q[5:0];
  assign fld[1] = snap_q[11:6];
  assign fld[2] = {1'b0, snap_q[16:12]};

  for (genvar gi = 0; gi < 3; gi++) begin : g_bcd
    localparam logic [5:0] LIM = (gi == 2) ? 6'd23 : 6'd59;
    logic [7:0] pair_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            pair_q <= '0;
      else if (fld[gi] > LIM) pair_q <= {DASH, DASH};
      else                   pair_q <= to_bcd(fld[gi]);
    end
    assign dig[2*gi]   = pair_q[3:0];
    assign dig[2*gi+1] = pair_q[7:4];
  end

`ifdef COLON_BLINK_EN
  logic sec_odd_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sec_odd_q <= 1'b0;
    else        sec_odd_q <= snap_q[0];
  end
`endif

  logic [PW-1:0] presc_q;
  logic [2:0]    idx_q;
  logic          tick;
  assign tick = (presc_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);
      if (tick) idx_q <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    end
  end

  logic [3:0] cur_dig;
  logic       sep;
  logic [5:0] an_d, an_q;
  logic [6:0] seg_d, seg_q;
  logic       dp_d, dp_q;

  always_comb begin
    case (idx_q)
      3'd1:    cur_dig = dig[1];
      3'd2:    cur_dig = dig[2];
      3'd3:    cur_dig = dig[3];
      3'd4:    cur_dig = dig[4];
      3'd5:    cur_dig = dig[5];
      default: cur_dig = dig[0];
    endcase
    sep = (idx_q == 3'd2) || (idx_q == 3'd4);
  end

  // The tick cycle is forced dark so the old digit never ghosts onto the next anode.
  always_comb begin
    an_d  = 6'h3F;
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (disp_en && !tick) begin
      an_d  = ~(6'b000001 << idx_q);
      seg_d = seg_code(cur_dig);
`ifdef COLON_BLINK_EN
      dp_d  = !(sep && !sec_odd_q);
`else
      dp_d  = !sep;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= 6'h3F;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;
endmodule
